// File: rtl/ram_fifo_pkg.sv
// Shared constants, flag bundle and helper functions for the RAM-backed FIFO.
// Default width/depth suit the note and sample paths between sequencer and tone generator.
package ram_fifo_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 64;

    typedef struct packed {
        logic empty;
        logic full;
        logic almost_empty;
        logic almost_full;
    } flags_t;

    function automatic int clog2(input int value);
        int bits = 0;
        int rem  = value - 1;
        while (rem > 0) begin
            bits++;
            rem = rem >> 1;
        end
        return bits;
    endfunction

    // Status flags for a given occupancy; also yields the reset values when occ is 0.
    function automatic flags_t flags_for(input int occ, input int depth,
                                         input int af_level, input int ae_level);
        flags_t f;
        f.empty        = (occ == 0);
        f.full         = (occ == depth);
        f.almost_empty = (occ <= ae_level);
        f.almost_full  = (occ >= af_level);
        return f;
    endfunction

endpackage

// File: rtl/ram_fifo_dp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port with a registered output.
module dp_ram
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW = clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: the storage array has no reset so it can map onto block RAM; only the output register is reset.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_fifo.sv
// Synchronous FIFO on a dual-port RAM with arbitrary depth, occupancy count,
// registered status flags, sticky overflow/underflow and a synchronous flush.
module ram_fifo
    import ram_fifo_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    localparam int AW = clog2(DEPTH),
    localparam int CW = clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [AW-1:0] LAST_ADDR   = AW'(DEPTH - 1);
    localparam flags_t        RESET_FLAGS = flags_for(0, DEPTH, AF_LEVEL, AE_LEVEL);

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic [CW-1:0] next_count;
    flags_t        next_flags;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + AW'(1);
    endfunction

    // Acceptance uses the registered full/empty, so an empty FIFO never falls through
    // and read/write addresses can never collide in the same cycle.
    assign push_ok = wr_en & ~full  & ~flush;
    assign pop_ok  = rd_en & ~empty & ~flush;

    always_comb begin
        next_count = count;
        if (flush) begin
            next_count = '0;
        end else if (push_ok && !pop_ok) begin
            next_count = count + CW'(1);
        end else if (pop_ok && !push_ok) begin
            next_count = count - CW'(1);
        end
        next_flags = flags_for(int'(next_count), DEPTH, AF_LEVEL, AE_LEVEL);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            {empty, full, almost_empty, almost_full} <= RESET_FLAGS;
            dout_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            wr_ptr     <= flush ? '0 : (push_ok ? bump(wr_ptr) : wr_ptr);
            rd_ptr     <= flush ? '0 : (pop_ok  ? bump(rd_ptr) : rd_ptr);
            count      <= next_count;
            {empty, full, almost_empty, almost_full} <= next_flags;
            dout_valid <= pop_ok;
            overflow   <= flush ? 1'b0 : (overflow  | (wr_en & full));
            underflow  <= flush ? 1'b0 : (underflow | (rd_en & empty));
        end
    end

    dp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (push_ok),
        .waddr   (wr_ptr),
        .wdata   (din),
        .re      (pop_ok),
        .raddr   (rd_ptr),
        .rdata   (dout)
    );

endmodule

// File: tb/tb_ram_fifo.sv
// Self-checking bench for ram_fifo: a DEPTH=5 instance for fill/drain/wrap/flush/reset
// and a DEPTH=64 instance for the almost-full/almost-empty thresholds.
module tb_ram_fifo;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    // Small instance: DEPTH=5, AF_LEVEL=1, AE_LEVEL=4.
    logic       a_flush, a_wr, a_rd;
    logic [7:0] a_din, a_dout;
    logic       a_dv, a_empty, a_full, a_ae, a_af, a_ovf, a_unf;
    logic [2:0] a_count;

    // Large instance: DEPTH=64, AF_LEVEL=60, AE_LEVEL=4.
    logic       b_flush, b_wr, b_rd;
    logic [7:0] b_din, b_dout;
    logic       b_dv, b_empty, b_full, b_ae, b_af, b_ovf, b_unf;
    logic [6:0] b_count;

    ram_fifo #(.WIDTH(8), .DEPTH(5)) dut_a (
        .clock(clock), .reset_n(reset_n), .flush(a_flush), .wr_en(a_wr), .din(a_din),
        .rd_en(a_rd), .dout(a_dout), .dout_valid(a_dv), .count(a_count), .empty(a_empty),
        .full(a_full), .almost_empty(a_ae), .almost_full(a_af), .overflow(a_ovf),
        .underflow(a_unf)
    );

    ram_fifo #(.WIDTH(8), .DEPTH(64), .AF_LEVEL(60), .AE_LEVEL(4)) dut_b (
        .clock(clock), .reset_n(reset_n), .flush(b_flush), .wr_en(b_wr), .din(b_din),
        .rd_en(b_rd), .dout(b_dout), .dout_valid(b_dv), .count(b_count), .empty(b_empty),
        .full(b_full), .almost_empty(b_ae), .almost_full(b_af), .overflow(b_ovf),
        .underflow(b_unf)
    );

    int         tests = 0;
    int         fails = 0;
    logic [7:0] model_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] last_dout = 8'h00;
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;
    int         b_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock on the small instance; the model decides acceptance from its own occupancy.
    task automatic cycle_a(input logic f, input logic w, input logic [7:0] d, input logic r);
        int   occ;
        logic push_ok;
        logic pop_ok;
        occ     = model_q.size();
        push_ok = !f && w && (occ < 5);
        pop_ok  = !f && r && (occ > 0);
        if (f) begin
            model_q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            if (w && occ == 5) m_ovf = 1'b1;
            if (r && occ == 0) m_unf = 1'b1;
            if (pop_ok)  exp_q.push_back(model_q.pop_front());
            if (push_ok) model_q.push_back(d);
        end
        a_flush = f;
        a_wr    = w;
        a_din   = d;
        a_rd    = r;
        @(posedge clock);
        #1;
        a_flush = 1'b0;
        a_wr    = 1'b0;
        a_rd    = 1'b0;
        check("a_dout_valid", a_dv, pop_ok);
        if (pop_ok && exp_q.size() > 0) last_dout = exp_q.pop_front();
        check("a_dout", a_dout, last_dout);
        check("a_count", a_count, model_q.size());
        check("a_empty", a_empty, model_q.size() == 0);
        check("a_full", a_full, model_q.size() == 5);
        check("a_almost_empty", a_ae, model_q.size() <= 4);
        check("a_almost_full", a_af, model_q.size() >= 1);
        check("a_overflow", a_ovf, m_ovf);
        check("a_underflow", a_unf, m_unf);
    endtask

    task automatic cycle_b(input logic w, input logic [7:0] d);
        b_wr  = w;
        b_din = d;
        if (w && b_cnt < 64) b_cnt++;
        @(posedge clock);
        #1;
        b_wr = 1'b0;
        check("b_count", b_count, b_cnt);
        check("b_almost_empty", b_ae, b_cnt <= 4);
        check("b_almost_full", b_af, b_cnt >= 60);
    endtask

    task automatic check_reset_values(input string when);
        check({when, "_a_count"}, a_count, 0);
        check({when, "_a_empty"}, a_empty, 1);
        check({when, "_a_full"}, a_full, 0);
        check({when, "_a_almost_empty"}, a_ae, 1);
        check({when, "_a_almost_full"}, a_af, 0);
        check({when, "_a_dout"}, a_dout, 0);
        check({when, "_a_dout_valid"}, a_dv, 0);
        check({when, "_a_overflow"}, a_ovf, 0);
        check({when, "_a_underflow"}, a_unf, 0);
        check({when, "_b_count"}, b_count, 0);
        check({when, "_b_almost_empty"}, b_ae, 1);
        check({when, "_b_almost_full"}, b_af, 0);
    endtask

    initial begin
        a_flush = 1'b0; a_wr = 1'b0; a_rd = 1'b0; a_din = 8'h00;
        b_flush = 1'b0; b_wr = 1'b0; b_rd = 1'b0; b_din = 8'h00;

        // Reset state.
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("reset");
        reset_n = 1'b1;

        // Fill 1..5, then a rejected 6th push sets overflow.
        for (int i = 1; i <= 5; i++) cycle_a(1'b0, 1'b1, 8'(i), 1'b0);
        cycle_a(1'b0, 1'b1, 8'h66, 1'b0);

        // Drain 1..5; a 6th pop sets underflow and dout holds 5.
        for (int i = 0; i < 6; i++) cycle_a(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous push/pop when empty: push only, underflow set.
        cycle_a(1'b1, 1'b0, 8'h00, 1'b0);
        cycle_a(1'b0, 1'b1, 8'h21, 1'b1);
        cycle_a(1'b1, 1'b0, 8'h00, 1'b0);

        // Simultaneous push/pop when full: pop only, overflow set.
        for (int i = 1; i <= 5; i++) cycle_a(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        cycle_a(1'b0, 1'b1, 8'h77, 1'b1);

        // Flush at count 3 takes priority over concurrent requests.
        cycle_a(1'b0, 1'b0, 8'h00, 1'b1);
        cycle_a(1'b1, 1'b1, 8'h99, 1'b1);

        // Wrap: 12 push/pop pairs at count 2 cross the pointer wrap several times.
        cycle_a(1'b0, 1'b1, 8'h0E, 1'b0);
        cycle_a(1'b0, 1'b1, 8'h0F, 1'b0);
        for (int i = 0; i < 12; i++) cycle_a(1'b0, 1'b1, 8'(8'h10 + i), 1'b1);

        // Thresholds on the deep instance.
        for (int i = 0; i < 62; i++) cycle_b(1'b1, 8'(i));

        // Asynchronous reset between edges, mid-stream.
        cycle_a(1'b0, 1'b1, 8'hAA, 1'b1);
        a_wr = 1'b1;
        a_rd = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        a_wr = 1'b0;
        a_rd = 1'b0;
        model_q.delete();
        exp_q.delete();
        last_dout = 8'h00;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        b_cnt = 0;
        #2 reset_n = 1'b1;

        // Normal operation resumes after reset.
        cycle_a(1'b0, 1'b1, 8'h5A, 1'b0);
        cycle_a(1'b0, 1'b0, 8'h00, 1'b1);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
